// File: rtl/uart_telemetry_tx_if.sv
// Sample handshake between a telemetry producer and the UART frame transmitter.
// The producer offers {channel, RPM} with tx_valid_i; tx_ready_o reports free buffer space.
interface uart_telemetry_tx_if #(
  parameter int CHN_WIDTH  = 2,
  parameter int DATA_WIDTH = 16
);
  logic                  tx_valid_i;
  logic [CHN_WIDTH-1:0]  tx_chn_i;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_ready_o;

  modport master (output tx_valid_i, output tx_chn_i, output tx_data_i, input tx_ready_o);
  modport slave  (input tx_valid_i, input tx_chn_i, input tx_data_i, output tx_ready_o);
endinterface

// File: rtl/uart_telemetry_tx.sv
// Buffers RPM samples and sends each one as a 5-byte 8N1 frame:
// 0xA5, channel, data[15:8], data[7:0], checksum over the three payload bytes.
module uart_telemetry_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHN    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  uart_telemetry_tx_if.slave s_tx,
  output logic               uart_tx,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CHN_WIDTH    = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W      = CHN_WIDTH + DATA_WIDTH;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]       HEADER    = 8'hA5;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  function automatic logic [7:0] checksum(input logic [7:0] b1, input logic [7:0] b2,
                                          input logic [7:0] b3);
    return b1 + b2 + b3;
  endfunction

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [PTR_W:0]     r_count;
  logic               r_ready;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit;
  logic [2:0]         r_byte;
  logic [39:0]        r_frame;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_bit_end;
  logic [PTR_W:0]     w_count_nxt;
  logic [ENTRY_W-1:0] w_head;
  logic [7:0]         w_b1;
  logic [7:0]         w_b2;
  logic [7:0]         w_b3;
  logic [7:0]         w_cks;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         w_bit_nxt;
  logic [2:0]         w_byte_nxt;
  logic [39:0]        w_frame_nxt;
  logic               w_tx_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  assign w_push    = s_tx.tx_valid_i && r_ready;
  assign w_empty   = (r_count == '0);
  assign w_bit_end = (r_cnt == BIT_LAST);
  assign w_head    = r_mem[r_rd];
  assign w_b1      = 8'(w_head[ENTRY_W-1 -: CHN_WIDTH]);
  assign w_b2      = w_head[15:8];
  assign w_b3      = w_head[7:0];
  assign w_cks     = checksum(w_b1, w_b2, w_b3);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (PTR_W + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FIFO_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {s_tx.tx_chn_i, s_tx.tx_data_i};
  end

  // The frame is one 40-bit shift register, header in the low byte, shifted once per data bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_frame_nxt = r_frame;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_pop       = 1'b1;
        w_frame_nxt = {w_cks, w_b3, w_b2, w_b1, HEADER};
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_byte_nxt  = '0;
        w_state_nxt = START;
      end
      START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_frame_nxt = r_frame >> 1;
          if (r_bit == 3'd7) w_state_nxt = STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_byte != 3'd4) begin
            w_byte_nxt  = r_byte + 3'd1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = w_empty ? IDLE : LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are derived from the next state so the registered copies line up with r_state.
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_frame_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == STOP) && (w_cnt_nxt == BIT_LAST) && (w_byte_nxt == 3'd4);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_frame <= w_frame_nxt;
  end

  assign s_tx.tx_ready_o = r_ready;
  assign uart_tx         = r_tx;
  assign busy_o          = r_busy;
  assign frame_done_o    = r_done;

endmodule

// File: tb/tb_uart_telemetry_tx.sv
// Bench for uart_telemetry_tx: a serial-line receiver decodes the bytes on uart_tx and
// compares them with frames built from the sample values.
module tb_uart_telemetry_tx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int CHN_W    = 2;
  localparam int DW       = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic uart_tx;
  logic busy_o;
  logic frame_done_o;

  uart_telemetry_tx_if #(.CHN_WIDTH(CHN_W), .DATA_WIDTH(DW)) tif ();

  uart_telemetry_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_WIDTH(DW), .NUM_CHN(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .s_tx(tif), .uart_tx(uart_tx), .busy_o(busy_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  chn;
    logic [15:0] data;
    logic [7:0]  b1, b2, b3, b4;
  } vec_t;

  vec_t vecs [5];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  int rx_err = 0, gap_err = 0, busy_err = 0, done_err = 0, n_done = 0, n_low = 0;
  int cyc = 0, last_start = 0, rx_cyc = 0, rx_idx = 0;
  bit have_prev = 1'b0, rx_active = 1'b0, exp_done;
  logic [9:0] rx_v;

  // Line receiver: 10 cycles per bit, every bit must be constant over its whole period.
  always @(posedge clk) begin
    #2;
    cyc++;
    exp_done = 1'b0;
    if (!rstn) begin
      rx_active = 1'b0;
      rx_idx    = 0;
      have_prev = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        if (have_prev) begin
          if (rx_idx != 0) begin
            if (cyc != last_start + 100) gap_err++;
          end else if (cyc < last_start + 101) begin
            gap_err++;
          end
        end
        last_start = cyc;
        have_prev  = 1'b1;
        rx_active  = 1'b1;
        rx_cyc     = 0;
      end
    end else begin
      rx_cyc++;
    end
    if (rstn && rx_active) begin
      if (rx_cyc % 10 == 0) rx_v[rx_cyc / 10] = uart_tx;
      else if (uart_tx !== rx_v[rx_cyc / 10]) rx_err++;
      if (busy_o !== 1'b1) busy_err++;
      if (rx_cyc == 99) begin
        exp_done = (rx_idx == 4);
        if (rx_v[0] !== 1'b0 || rx_v[9] !== 1'b1) rx_err++;
        rx_q.push_back(rx_v[8:1]);
        rx_idx    = (rx_idx == 4) ? 0 : rx_idx + 1;
        rx_active = 1'b0;
      end
    end
    if (rstn && uart_tx === 1'b0) n_low++;
    if (frame_done_o !== exp_done) done_err++;
    if (frame_done_o === 1'b1) n_done++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic void model_frame(input int chn, input int data);
    int hi, lo;
    hi = (data >> 8) & 255;
    lo = data & 255;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(chn));
    exp_q.push_back(8'(hi));
    exp_q.push_back(8'(lo));
    exp_q.push_back(8'((chn + hi + lo) % 256));
  endfunction

  task automatic send(input logic [1:0] chn, input logic [15:0] data, output bit acc);
    tif.tx_valid_i = 1'b1;
    tif.tx_chn_i   = chn;
    tif.tx_data_i  = data;
    acc = tif.tx_ready_o;
    tick();
    tif.tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    ticks(3);
    while ((busy_o || rx_active) && k < limit) begin
      tick();
      k++;
    end
    chk({name, "_idle_reached"}, int'(k < limit), 1);
    ticks(2);
  endtask

  task automatic compare_rx(input string name);
    chk({name, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), int'(rx_q[i]), int'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k;
    int nacc;

    vecs[0] = '{2'd2, 16'h1234, 8'h02, 8'h12, 8'h34, 8'h48};
    vecs[1] = '{2'd3, 16'hFFFF, 8'h03, 8'hFF, 8'hFF, 8'h01};
    vecs[2] = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{2'd1, 16'hA5A5, 8'h01, 8'hA5, 8'hA5, 8'h4B};
    vecs[4] = '{2'd3, 16'h8001, 8'h03, 8'h80, 8'h01, 8'h84};

    tif.tx_valid_i = 1'b0;
    tif.tx_chn_i   = '0;
    tif.tx_data_i  = '0;
    ticks(3);
    chk("rst_uart_tx", int'(uart_tx), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_frame_done", int'(frame_done_o), 0);
    chk("rst_ready", int'(tif.tx_ready_o), 0);
    rstn = 1'b1;
    tick();
    chk("rst_release_ready", int'(tif.tx_ready_o), 1);
    ticks(2);

    // Latency from the accepting edge N, then frame timing.
    n_done = 0;
    send(vecs[0].chn, vecs[0].data, acc);
    chk("lat_accept", int'(acc), 1);
    chk("lat_busy_N", int'(busy_o), 0);
    tick();
    chk("lat_busy_N1", int'(busy_o), 1);
    chk("lat_line_N1", int'(uart_tx), 1);
    tick();
    chk("lat_line_N2", int'(uart_tx), 0);
    k = 2;
    while (!frame_done_o && k < 600) begin
      tick();
      k++;
    end
    chk("lat_done_edge", k, 501);
    tick();
    chk("lat_done_pulse_end", int'(frame_done_o), 0);
    chk("lat_busy_end", int'(busy_o), 0);
    exp_q = '{8'hA5, vecs[0].b1, vecs[0].b2, vecs[0].b3, vecs[0].b4};
    wait_idle("lat", 100);
    compare_rx("lat");
    chk("lat_ndone", n_done, 1);

    for (int i = 1; i < 5; i++) begin
      n_done = 0;
      send(vecs[i].chn, vecs[i].data, acc);
      chk($sformatf("vec%0d_accept", i), int'(acc), 1);
      exp_q = '{8'hA5, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].b4};
      wait_idle($sformatf("vec%0d", i), 700);
      compare_rx($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ndone", i), n_done, 1);
    end

    // Two queued samples: one high, busy cycle between frames.
    n_done = 0;
    send(2'd1, 16'h0F0F, acc);
    if (acc) model_frame(1, 16'h0F0F);
    send(2'd2, 16'hBEEF, acc);
    if (acc) model_frame(2, 16'hBEEF);
    k = 0;
    while (!frame_done_o && k < 700) begin
      tick();
      k++;
    end
    chk("b2b_first_done_seen", int'(k < 700), 1);
    tick();
    chk("b2b_gap_line", int'(uart_tx), 1);
    chk("b2b_gap_busy", int'(busy_o), 1);
    tick();
    chk("b2b_f2_start_line", int'(uart_tx), 0);
    chk("b2b_f2_start_busy", int'(busy_o), 1);
    wait_idle("b2b", 700);
    compare_rx("b2b");
    chk("b2b_ndone", n_done, 2);

    // Six offers held back-to-back from idle: the sixth meets a full buffer.
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tif.tx_valid_i = 1'b1;
      tif.tx_chn_i   = 2'(i % 4);
      tif.tx_data_i  = 16'(16'h1000 + i * 16'h0111);
      chk($sformatf("ovf_ready_before_%0d", i), int'(tif.tx_ready_o), int'(i < 5));
      if (i < 5) model_frame(i % 4, 16'h1000 + i * 16'h0111);
      tick();
    end
    tif.tx_valid_i = 1'b0;
    chk("ovf_ready_hold", int'(tif.tx_ready_o), 0);
    wait_idle("ovf", 3000);
    compare_rx("ovf");
    chk("ovf_ndone", n_done, 5);

    // Reset during data bits of byte 2 with a second sample still queued.
    n_done = 0;
    send(2'd1, 16'h0055, acc);
    send(2'd2, 16'h0102, acc);
    ticks(235);
    chk("mid_rst_line_before", int'(uart_tx), 0);
    rstn = 1'b0;
    tick();
    chk("mid_rst_line", int'(uart_tx), 1);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_done", int'(frame_done_o), 0);
    chk("mid_rst_ready", int'(tif.tx_ready_o), 0);
    ticks(2);
    rstn = 1'b1;
    rx_q.delete();
    exp_q.delete();
    n_low  = 0;
    n_done = 0;
    ticks(1200);
    chk("mid_rst_no_line_activity", n_low, 0);
    chk("mid_rst_no_done", n_done, 0);
    chk("mid_rst_idle_busy", int'(busy_o), 0);
    chk("mid_rst_ready_after", int'(tif.tx_ready_o), 1);
    chk("mid_rst_no_bytes", rx_q.size(), 0);

    // Randomised offers with random spacing.
    n_done = 0;
    nacc   = 0;
    for (int i = 0; i < 14; i++) begin
      logic [1:0]  c;
      logic [15:0] d;
      ticks($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      send(c, d, acc);
      if (acc) begin
        model_frame(int'(c), int'(d));
        nacc++;
      end
    end
    wait_idle("rnd", 9000);
    compare_rx("rnd");
    chk("rnd_ndone", n_done, nacc);

    chk("line_bit_framing_errors", rx_err, 0);
    chk("byte_spacing_errors", gap_err, 0);
    chk("busy_low_while_sending", busy_err, 0);
    chk("frame_done_misaligned", done_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_telemetry_tx.md
UART_TELEMETRY_TX -- requirements
Module: uart_telemetry_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), legal only if >= 4.
REQ-003 Parameter DATA_WIDTH, default 16, RPM sample width; 16 is the only supported value.
REQ-004 Parameter NUM_CHN, default 4, channel count; CHN_WIDTH = (NUM_CHN>1) ? clog2(NUM_CHN) : 1.
REQ-005 Parameter FIFO_DEPTH, default 4, sample buffer entries (power of 2, >= 2).
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rstn  input  1  reset, synchronous, active-low.
REQ-008 tx_valid_i  input  1  sample offered.
REQ-009 tx_chn_i  input  CHN_WIDTH  channel index of the offered sample.
REQ-010 tx_data_i  input  DATA_WIDTH  RPM value of the offered sample.
REQ-011 tx_ready_o  output  1  block can accept a sample (= FIFO not full).
REQ-012 uart_tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-013 busy_o  output  1  a frame is being transmitted.
REQ-014 frame_done_o  output  1  one-cycle pulse when a frame is complete.

Function
REQ-015 A sample SHALL be accepted on a rising edge where tx_valid_i && tx_ready_o; chn and data are written to the FIFO on that edge.
REQ-016 tx_ready_o SHALL be registered and low whenever the FIFO holds FIFO_DEPTH entries; offers while it is low are ignored, not stored.
REQ-017 Each sample SHALL become one 5-byte frame: 0xA5, {zero-extended chn}, data[15:8], data[7:0], checksum.
REQ-018 Checksum SHALL be (byte1 + byte2 + byte3) mod 256; the header is excluded.
REQ-019 Each byte SHALL be one start bit (0), 8 data bits LSB first, and one stop bit (1); every bit is held exactly CLKS_PER_BIT cycles.
REQ-020 Bytes within a frame SHALL be back-to-back: the next start bit follows the previous stop bit with no idle cycles.
REQ-021 FSM states: IDLE, LOAD, START, DATA, STOP. IDLE->LOAD when FIFO non-empty; LOAD pops one entry and builds the frame (1 cycle); LOAD->START; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bits; STOP->START if byte index < 4, else frame end.
REQ-022 At frame end, the FSM SHALL go to LOAD if the FIFO is non-empty, else IDLE; this adds one idle-high cycle between frames.
REQ-023 Latency: with the FIFO empty and IDLE, uart_tx SHALL fall on the 2nd rising edge after the accepting edge.
REQ-024 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit or an occupancy counter.
REQ-026 busy_o SHALL be high in LOAD, START, DATA and STOP, and low in IDLE.
REQ-027 frame_done_o SHALL pulse high for exactly the last cycle of the stop bit of byte 4.
REQ-028 uart_tx, busy_o and frame_done_o SHALL be registered outputs.

Reset
REQ-029 While rstn is low at a rising edge, the block SHALL set uart_tx=1, busy_o=0, frame_done_o=0, tx_ready_o=0, FIFO empty, FSM=IDLE, and all counters to 0.
REQ-030 tx_ready_o SHALL go high on the first rising edge at which rstn is sampled high.
REQ-031 Reset mid-frame SHALL abort the frame: the line returns high on that edge, buffered samples are discarded, and no frame_done_o pulse is produced.

Verification (CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10)
REQ-032 Single sample chn=2, data=0x1234 -> line bytes A5 02 12 34 48, each bit 10 cycles, 500 cycles start-to-stop-end, one frame_done_o pulse.
REQ-033 Latency: accept at edge N from idle -> uart_tx low at edge N+2 and busy_o high at edge N+1.
REQ-034 Overflow: 6 consecutive pushes while idle -> 4 accepted by FIFO, 1 popped into LOAD, tx_ready_o low thereafter -> exactly 5 frames sent in order, the 6th offer is not stored.
REQ-035 Checksum wrap: chn=3, data=0xFFFF -> bytes A5 03 FF FF 01.
REQ-036 Back-to-back frames: 2 queued samples -> exactly one idle-high cycle between the stop bit of frame 1 and the start bit of frame 2; busy_o stays high across that cycle.
REQ-037 Reset asserted during DATA of byte 2 with 2 samples queued -> uart_tx=1 and busy_o=0 on that edge, then no further frames after release.
